// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I opcode, funct7 and encoder state definitions
package riscv_pkg;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } enc_state_t;

endpackage

// File: rtl/instr_packer.sv
// rtl/instr_packer.sv - combinational RV32I field packing and immediate range checking
module instr_packer
  import riscv_pkg::*;
#(
  parameter int INSTR_WIDTH   = 32,
  parameter int REG_NAME_BITS = 5,
  parameter int FUNC_BITS     = 3,
  parameter int OP_BITS       = 7
) (
  input  logic [OP_BITS-1:0]       op,
  input  logic [REG_NAME_BITS-1:0] rd,
  input  logic [REG_NAME_BITS-1:0] rs1,
  input  logic [REG_NAME_BITS-1:0] rs2,
  input  logic [FUNC_BITS-1:0]     funct3,
  input  logic                     alt_op,
  input  logic [INSTR_WIDTH-1:0]   imm,
  output logic [INSTR_WIDTH-1:0]   word,
  output logic                     ok
);

  logic       i_fits;
  logic       b_fits;
  logic       j_fits;
  logic       u_fits;
  logic       sh_fits;
  logic [6:0] funct7;

  // Range checks: the immediate must equal its own sign extension from the field width.
  always_comb begin
    i_fits  = (imm == {{(INSTR_WIDTH-12){imm[11]}}, imm[11:0]});
    b_fits  = (imm == {{(INSTR_WIDTH-13){imm[12]}}, imm[12:0]}) && !imm[0];
    j_fits  = (imm == {{(INSTR_WIDTH-21){imm[20]}}, imm[20:0]}) && !imm[0];
    u_fits  = (imm[11:0] == 12'd0);
    sh_fits = (imm[INSTR_WIDTH-1:5] == '0);
  end

  // Pack fields by format; unknown opcodes produce ok = 0.
  always_comb begin
    word   = '0;
    ok     = 1'b0;
    funct7 = FUNCT7_BASE;
    case (op)
      OP: begin
        if (alt_op && (funct3 == 3'b000 || funct3 == 3'b101)) funct7 = FUNCT7_ALT;
        word = {funct7, rs2, rs1, funct3, rd, op};
        ok   = 1'b1;
      end
      OP_IMM: begin
        if (funct3 == 3'b001) begin
          word = {7'b0, imm[4:0], rs1, funct3, rd, op};
          ok   = sh_fits;
        end else if (funct3 == 3'b101) begin
          word = {1'b0, alt_op, 5'b0, imm[4:0], rs1, funct3, rd, op};
          ok   = sh_fits;
        end else begin
          word = {imm[11:0], rs1, funct3, rd, op};
          ok   = i_fits;
        end
      end
      LOAD, MISC_MEM, SYSTEM: begin
        word = {imm[11:0], rs1, funct3, rd, op};
        ok   = i_fits;
      end
      JALR: begin
        word = {imm[11:0], rs1, 3'b000, rd, op};
        ok   = i_fits;
      end
      STORE: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
        ok   = i_fits;
      end
      BRANCH: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
        ok   = b_fits;
      end
      LUI, AUIPC: begin
        word = {imm[31:12], rd, op};
        ok   = u_fits;
      end
      JAL: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        ok   = j_fits;
      end
      default: begin
        word = '0;
        ok   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - sequential RV32I encoder writing packed words to instruction memory
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int INSTR_WIDTH   = 32,
  parameter int REG_NAME_BITS = 5,
  parameter int FUNC_BITS     = 3,
  parameter int OP_BITS       = 7,
  parameter int ADDR_BITS     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [ADDR_BITS-1:0]     base_addr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_BITS-1:0]       op,
  input  logic [REG_NAME_BITS-1:0] rd,
  input  logic [REG_NAME_BITS-1:0] rs1,
  input  logic [REG_NAME_BITS-1:0] rs2,
  input  logic [FUNC_BITS-1:0]     funct3,
  input  logic                     alt_op,
  input  logic [INSTR_WIDTH-1:0]   imm,
  output logic                     mem_we,
  output logic [ADDR_BITS-1:0]     mem_addr,
  output logic [INSTR_WIDTH-1:0]   mem_wdata,
  output logic [ADDR_BITS:0]       count,
  output logic                     full,
  output logic                     err,
  output logic [OP_BITS-1:0]       err_op
);

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_BITS:0]   CNT_ONE  = 1;

  enc_state_t               state_q, state_d;
  logic [ADDR_BITS-1:0]     addr_q;
  logic [ADDR_BITS:0]       count_q;
  logic                     err_q;
  logic [OP_BITS-1:0]       err_op_q;
  logic                     mem_we_q;
  logic [ADDR_BITS-1:0]     mem_addr_q;
  logic [INSTR_WIDTH-1:0]   mem_wdata_q;
  logic [INSTR_WIDTH-1:0]   word;
  logic                     ok;
  logic                     xfer;
  logic                     accept;
  logic                     reject;

  instr_packer #(
    .INSTR_WIDTH   (INSTR_WIDTH),
    .REG_NAME_BITS (REG_NAME_BITS),
    .FUNC_BITS     (FUNC_BITS),
    .OP_BITS       (OP_BITS)
  ) u_packer (
    .op     (op),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .alt_op (alt_op),
    .imm    (imm),
    .word   (word),
    .ok     (ok)
  );

  assign in_ready = (state_q == ST_RUN);
  assign xfer     = in_valid && in_ready;
  assign accept   = xfer && ok;
  assign reject   = xfer && !ok;

  // Next state: stop beats the transition into FULL, start only acts from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (stop) state_d = ST_IDLE;
        else if (accept && (&addr_q)) state_d = ST_FULL;
      end
      ST_FULL: if (stop) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, address counter, error capture and registered memory write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      err_op_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= accept;
      if (state_q == ST_IDLE && start) begin
        addr_q   <= base_addr;
        count_q  <= '0;
        err_q    <= 1'b0;
        err_op_q <= '0;
      end
      if (accept) begin
        mem_addr_q  <= addr_q;
        mem_wdata_q <= word;
        addr_q      <= addr_q + ADDR_ONE;
        count_q     <= count_q + CNT_ONE;
      end
      if (reject) begin
        err_q <= 1'b1;
        if (!err_q) err_op_q <= op;
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign full      = (state_q == ST_FULL);
  assign err       = err_q;
  assign err_op    = err_op_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stop, in_valid, alt_op;
  logic [7:0]  base_addr;
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        in_ready, mem_we, full, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  count;
  logic [6:0]  err_op;

  logic        start2, stop2, in_valid2;
  logic [1:0]  base_addr2;
  logic        in_ready2, mem_we2, full2, err2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  count2;
  logic [6:0]  err_op2;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0]  exp_addr, exp_last_addr;
  logic [8:0]  exp_count;
  logic [31:0] exp_last_data;
  logic        exp_err;
  logic [6:0]  exp_err_op;

  instr_encoder dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .alt_op(alt_op), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .count(count), .full(full), .err(err), .err_op(err_op)
  );

  instr_encoder #(.ADDR_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(stop2), .base_addr(base_addr2),
    .in_valid(in_valid2), .in_ready(in_ready2), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .alt_op(alt_op), .imm(imm), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .count(count2), .full(full2), .err(err2), .err_op(err_op2)
  );

  // Reference: {ok, word} computed from the field-layout rules with integer arithmetic.
  function automatic logic [32:0] ref_encode(input logic [6:0] o, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f, input logic a,
      input logic [31:0] im);
    int si;
    logic ok;
    logic [31:0] w, low;
    si  = $signed(im);
    ok  = 1'b0;
    w   = 32'd0;
    low = (32'(s1) << 15) | (32'(f) << 12) | (32'(d) << 7) | 32'(o);
    case (o)
      7'h33: begin
        ok = 1'b1;
        w = ((a && (f == 3'd0 || f == 3'd5)) ? 32'h4000_0000 : 32'd0) | (32'(s2) << 20) | low;
      end
      7'h13: begin
        if (f == 3'd1 || f == 3'd5) begin
          ok = (im < 32);
          w = ((32'(im[4:0]) | ((f == 3'd5 && a) ? 32'h400 : 32'd0)) << 20) | low;
        end else begin
          ok = (si >= -2048 && si <= 2047);
          w = (32'(si & 'hfff) << 20) | low;
        end
      end
      7'h03, 7'h0F, 7'h73: begin
        ok = (si >= -2048 && si <= 2047);
        w = (32'(si & 'hfff) << 20) | low;
      end
      7'h67: begin
        ok = (si >= -2048 && si <= 2047);
        w = (32'(si & 'hfff) << 20) | (32'(s1) << 15) | (32'(d) << 7) | 32'(o);
      end
      7'h23: begin
        ok = (si >= -2048 && si <= 2047);
        w = (32'((si >> 5) & 127) << 25) | (32'(s2) << 20) | (32'(s1) << 15) |
            (32'(f) << 12) | (32'(si & 31) << 7) | 32'(o);
      end
      7'h63: begin
        ok = (si >= -4096 && si <= 4095 && (si % 2) == 0);
        w = (32'((si >> 12) & 1) << 31) | (32'((si >> 5) & 63) << 25) | (32'(s2) << 20) |
            (32'(s1) << 15) | (32'(f) << 12) | (32'((si >> 1) & 15) << 8) |
            (32'((si >> 11) & 1) << 7) | 32'(o);
      end
      7'h37, 7'h17: begin
        ok = ((im % 4096) == 0);
        w = (im - (im % 4096)) | (32'(d) << 7) | 32'(o);
      end
      7'h6F: begin
        ok = (si >= -1048576 && si <= 1048575 && (si % 2) == 0);
        w = (32'((si >> 20) & 1) << 31) | (32'((si >> 1) & 1023) << 21) |
            (32'((si >> 11) & 1) << 20) | (32'((si >> 12) & 255) << 12) |
            (32'(d) << 7) | 32'(o);
      end
      default: begin
        ok = 1'b0;
        w = 32'd0;
      end
    endcase
    return {ok, w};
  endfunction

  task automatic set_fields(input logic [6:0] o, input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [2:0] f, input logic a, input logic [31:0] im);
    op = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f; alt_op = a; imm = im;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0; base_addr = 8'd0;
    start2 = 1'b0; stop2 = 1'b0; in_valid2 = 1'b0; base_addr2 = 2'd0;
    set_fields(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    n_cmp++; if ({mem_addr, mem_wdata, count} !== '0) begin n_fail++; $display("FAIL reset_data got=%h/%h/%h want=0", mem_addr, mem_wdata, count); end
    n_cmp++; if ({full, err, err_op} !== '0) begin n_fail++; $display("FAIL reset_flags got=%b/%b/%h want=0", full, err, err_op); end
    n_cmp++; if ({in_ready2, mem_we2, mem_addr2, mem_wdata2, count2, full2, err2, err_op2} !== '0) begin n_fail++; $display("FAIL reset_dut2 got nonzero outputs want=0"); end
  endtask

  task automatic test_first_write();
    base_addr = 8'h10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL start_ready got=%b want=1", in_ready); end
    set_fields(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL first_we got=%b want=1", mem_we); end
    n_cmp++; if (mem_addr !== 8'h10) begin n_fail++; $display("FAIL first_addr got=%h want=10", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h00500093) begin n_fail++; $display("FAIL first_data got=%h want=00500093", mem_wdata); end
    n_cmp++; if (count !== 9'd1) begin n_fail++; $display("FAIL first_count got=%0d want=1", count); end
    exp_addr = 8'h11; exp_count = 9'd1; exp_err = 1'b0; exp_err_op = 7'd0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [3] = '{32'h002081B3, 32'h402081B3, 32'h40315093};
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_fields(OP, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
        1: set_fields(OP, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
        default: set_fields(OP_IMM, 5'd1, 5'd2, 5'd0, 3'd5, 1'b1, 32'd3);
      endcase
      in_valid = 1'b1;
      start = (i == 1);
      base_addr = 8'h80;
      @(posedge clk); #1 start = 1'b0;
      n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_we[%0d] got=%b want=1", i, mem_we); end
      n_cmp++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL b2b_addr[%0d] got=%h want=%h", i, mem_addr, exp_addr); end
      n_cmp++; if (mem_wdata !== want[i]) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, mem_wdata, want[i]); end
      exp_addr++; exp_count++;
      n_cmp++; if (count !== exp_count) begin n_fail++; $display("FAIL b2b_count[%0d] got=%0d want=%0d", i, count, exp_count); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (mem_we !== 1'b0 || mem_wdata !== 32'h40315093) begin n_fail++; $display("FAIL b2b_hold got=%b/%h want=0/40315093", mem_we, mem_wdata); end
  endtask

  task automatic test_transfers();
    logic [31:0] want [4] = '{32'h0020A423, 32'h00208463, 32'h010000EF, 32'h123452B7};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_fields(STORE, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8);
        1: set_fields(BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8);
        2: set_fields(JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd16);
        default: set_fields(LUI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000);
      endcase
      in_valid = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (mem_we !== 1'b1 || mem_addr !== exp_addr) begin n_fail++; $display("FAIL xfer_we_addr[%0d] got=%b/%h want=1/%h", i, mem_we, mem_addr, exp_addr); end
      n_cmp++; if (mem_wdata !== want[i]) begin n_fail++; $display("FAIL xfer_data[%0d] got=%h want=%h", i, mem_wdata, want[i]); end
      exp_addr++; exp_count++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reject();
    set_fields(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048); in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rej1_we got=%b want=0", mem_we); end
    n_cmp++; if (err !== 1'b1 || err_op !== 7'h13) begin n_fail++; $display("FAIL rej1_err got=%b/%h want=1/13", err, err_op); end
    n_cmp++; if (count !== exp_count || in_ready !== 1'b1) begin n_fail++; $display("FAIL rej1_count got=%0d/%b want=%0d/1", count, in_ready, exp_count); end
    set_fields(BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd7);
    @(posedge clk); #1;
    n_cmp++; if (mem_we !== 1'b0 || err_op !== 7'h13) begin n_fail++; $display("FAIL rej2 got=%b/%h want=0/13", mem_we, err_op); end
    set_fields(OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFF);
    @(posedge clk); #1 in_valid = 1'b0;
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== 32'hFFF00113) begin n_fail++; $display("FAIL rej_next got=%b/%h/%h want=1/%h/fff00113", mem_we, mem_addr, mem_wdata, exp_addr); end
    exp_last_addr = exp_addr; exp_last_data = 32'hFFF00113;
    exp_addr++; exp_count++; exp_err = 1'b1; exp_err_op = 7'h13;
  endtask

  task automatic test_random(input int n);
    logic [6:0] ops [11] = '{OP_IMM, LUI, AUIPC, OP, JAL, JALR, BRANCH, LOAD, STORE, MISC_MEM, SYSTEM};
    int edge_imm [13] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098, 31, 32, 1048574, 1048576, -1048576};
    logic [32:0] r;
    logic v, wrote;
    int k;
    for (int i = 0; i < n; i++) begin
      v = ($urandom_range(0, 4) != 0);
      k = $urandom_range(0, 11);
      op = (k == 11) ? 7'($urandom) : ops[k];
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      funct3 = 3'($urandom); alt_op = 1'($urandom);
      case ($urandom_range(0, 3))
        0: imm = 32'($signed($urandom_range(0, 127)) - 64);
        1: imm = 32'(edge_imm[$urandom_range(0, 12)]);
        2: imm = $urandom;
        default: imm = $urandom & 32'hFFFFF000;
      endcase
      in_valid = v;
      r = ref_encode(op, rd, rs1, rs2, funct3, alt_op, imm);
      @(posedge clk); #1;
      wrote = v && r[32];
      if (wrote) begin
        exp_last_addr = exp_addr; exp_last_data = r[31:0]; exp_addr++; exp_count++;
      end else if (v) begin
        if (!exp_err) exp_err_op = op;
        exp_err = 1'b1;
      end
      n_cmp++; if (mem_we !== wrote) begin n_fail++; $display("FAIL rnd_we[%0d] op=%h imm=%h got=%b want=%b", i, op, imm, mem_we, wrote); end
      n_cmp++; if (mem_addr !== exp_last_addr || mem_wdata !== exp_last_data) begin n_fail++; $display("FAIL rnd_word[%0d] op=%h f3=%0d imm=%h got=%h/%h want=%h/%h", i, op, funct3, imm, mem_addr, mem_wdata, exp_last_addr, exp_last_data); end
      n_cmp++; if (count !== exp_count || err !== exp_err || err_op !== exp_err_op) begin n_fail++; $display("FAIL rnd_state[%0d] got=%0d/%b/%h want=%0d/%b/%h", i, count, err, err_op, exp_count, exp_err, exp_err_op); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stop_with_transfer();
    set_fields(LUI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000);
    in_valid = 1'b1; stop = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; stop = 1'b0;
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== 32'h123452B7) begin n_fail++; $display("FAIL stop_write got=%b/%h/%h want=1/%h/123452b7", mem_we, mem_addr, mem_wdata, exp_addr); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stop_idle got=%b want=0", in_ready); end
    base_addr = 8'h40; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || count !== 9'd0 || err !== 1'b0) begin n_fail++; $display("FAIL restart got=%b/%0d/%b want=1/0/0", in_ready, count, err); end
    set_fields(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 8'h40 || count !== 9'd1) begin n_fail++; $display("FAIL restart_write got=%b/%h/%0d want=1/40/1", mem_we, mem_addr, count); end
  endtask

  task automatic test_full();
    base_addr2 = 2'd2; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    set_fields(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5); in_valid2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (mem_we2 !== 1'b1 || mem_addr2 !== 2'(2 + i) || mem_wdata2 !== 32'h00500093) begin n_fail++; $display("FAIL full_write[%0d] got=%b/%0d/%h want=1/%0d/00500093", i, mem_we2, mem_addr2, mem_wdata2, 2 + i); end
    end
    n_cmp++; if (full2 !== 1'b1 || in_ready2 !== 1'b0 || count2 !== 3'd2) begin n_fail++; $display("FAIL full_flag got=%b/%b/%0d want=1/0/2", full2, in_ready2, count2); end
    @(posedge clk); #1 in_valid2 = 1'b0;
    n_cmp++; if (mem_we2 !== 1'b0) begin n_fail++; $display("FAIL full_nowrite got=%b want=0", mem_we2); end
    stop2 = 1'b1;
    @(posedge clk); #1 stop2 = 1'b0;
    n_cmp++; if (full2 !== 1'b0 || in_ready2 !== 1'b0) begin n_fail++; $display("FAIL full_stop got=%b/%b want=0/0", full2, in_ready2); end
    start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0; in_valid2 = 1'b1;
    @(posedge clk); #1 in_valid2 = 1'b0;
    n_cmp++; if (mem_we2 !== 1'b1 || mem_addr2 !== 2'd2 || count2 !== 3'd1) begin n_fail++; $display("FAIL full_resume got=%b/%0d/%0d want=1/2/1", mem_we2, mem_addr2, count2); end
  endtask

  task automatic test_reset_mid();
    set_fields(OP, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got=%b want=1", mem_we); end
    @(posedge clk); #1 rst = 1'b0;
    n_cmp++; if ({mem_we, in_ready, full, err} !== 4'b0) begin n_fail++; $display("FAIL rstmid_flags got=%b%b%b%b want=0000", mem_we, in_ready, full, err); end
    n_cmp++; if ({mem_addr, mem_wdata, count, err_op} !== '0) begin n_fail++; $display("FAIL rstmid_data got=%h/%h/%h/%h want=0", mem_addr, mem_wdata, count, err_op); end
    start = 1'b1; base_addr = 8'h20;
    @(posedge clk); #1 start = 1'b0; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b0;
    n_cmp++; if (mem_we !== 1'b0 || in_ready !== 1'b0 || count !== 9'd0) begin n_fail++; $display("FAIL rst_drop got=%b/%b/%0d want=0/0/0", mem_we, in_ready, count); end
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_back_to_back();
    test_transfers();
    test_reject();
    test_random(120);
    test_stop_with_transfer();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
